// File: rtl/inst_fifo_pkg.sv
// Shared CPU types for the fetch-to-decode instruction buffer.
package inst_fifo_pkg;

    localparam int unsigned INST_FIFO_DEPTH = 16;

    // Decode treats an all-zero instruction word as a no-op.
    localparam logic [31:0] NOP_WORD = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Dual-issue instruction buffer: two pushes from fetch, head/head+1 to the
// master/slave decode slots, zero/one/two retired per cycle.
module inst_fifo
    import inst_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = INST_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid1,
    input  logic        in_valid2,
    input  logic [31:0] in_inst1,
    input  logic [31:0] in_inst2,
    input  logic [31:0] in_pc1,
    input  logic [31:0] in_pc2,
    output logic        full,
    output logic        empty,
    input  logic        pop_master,
    input  logic        pop_slave,
    output logic        out_valid1,
    output logic        out_valid2,
    output logic [31:0] out_inst1,
    output logic [31:0] out_inst2,
    output logic [31:0] out_pc1,
    output logic [31:0] out_pc2
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fifo_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr_p1;
    logic [PTR_W-1:0]   wr_ptr_p1;
    logic [CNT_W-1:0]   count;
    logic [1:0]         npush;
    logic [1:0]         npop;
    fifo_entry_t        head;
    fifo_entry_t        head_p1;

    // Status is a pure decode of the registered count.
    assign full       = (count > CNT_W'(DEPTH - 2));
    assign empty      = (count == '0);
    assign out_valid1 = (count >= CNT_W'(1));
    assign out_valid2 = (count >= CNT_W'(2));

    assign rd_ptr_p1 = rd_ptr + PTR_W'(1);
    assign wr_ptr_p1 = wr_ptr + PTR_W'(1);

    // Slot2 without slot1 is ignored; pushes while full are dropped.
    always_comb begin
        npush = 2'd0;
        npop  = 2'd0;
        if (in_valid1 && !full) begin
            npush = in_valid2 ? 2'd2 : 2'd1;
        end
        if (pop_master && out_valid1) begin
            npop = (pop_slave && out_valid2) ? 2'd2 : 2'd1;
        end
    end

    // Storage is never cleared; validity comes only from count.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (npush != 2'd0) begin
                mem[wr_ptr] <= '{pc: in_pc1, inst: in_inst1};
            end
            if (npush == 2'd2) begin
                mem[wr_ptr_p1] <= '{pc: in_pc2, inst: in_inst2};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(npop);
            wr_ptr <= wr_ptr + PTR_W'(npush);
            count  <= count + CNT_W'(npush) - CNT_W'(npop);
        end
    end

    assign head    = mem[rd_ptr];
    assign head_p1 = mem[rd_ptr_p1];

    assign out_inst1 = out_valid1 ? head.inst    : NOP_WORD;
    assign out_pc1   = out_valid1 ? head.pc      : 32'h0;
    assign out_inst2 = out_valid2 ? head_p1.inst : NOP_WORD;
    assign out_pc2   = out_valid2 ? head_p1.pc   : 32'h0;

endmodule
